decode_stage: RTL and testbench

- Instruction-decode stage sitting directly upstream of the 4x8 register file (R0-R2 general purpose, R3 = SP).
- Accepts instruction bytes from fetch over a valid/ready handshake and drives the register file's asynchronous read addresses combinationally.
- Registers the decoded control word (write enable, destination, SP control, ALU op, immediate) into the ID/EX pipeline register.
- Handles two-byte LDM, load-use stall, downstream stall and flush.

---
 rtl/isa_pkg.sv | 56 +++++
 rtl/decode_rom.sv | 55 +++++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, SP index, FSM states,
// the decode ROM control word and the ID/EX pipeline word.
package isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_PUSH = 4'h7;
    localparam logic [3:0] OP_POP  = 4'h8;
    localparam logic [3:0] OP_LDM  = 4'hC;

    localparam logic [1:0] SP_IDX = 2'd3;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_RA   = 2'd1,
        RD_RB   = 2'd2
    } rd_sel_t;

    typedef struct packed {
        logic    legal;
        logic    two_byte;
        rd_sel_t rd_sel;
        logic    wen;
        logic    sp_en;
        logic    sp_op;
        logic    mem_rd;
        logic    mem_wr;
        logic    use_imm;
        logic    src_ra;
        logic    src_rb;
        logic    src_sp;
    } ctrl_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic [1:0] rd;
        logic       wen;
        logic       sp_en;
        logic       sp_op;
        logic       mem_rd;
        logic       mem_wr;
        logic [7:0] imm;
        logic       use_imm;
    } idex_t;

endpackage

// File: rtl/decode_rom.sv
// Combinational opcode -> control-word lookup, including which registers
// each opcode reads (used by the load-use hazard check).
module decode_rom
    import isa_pkg::*;
(
    input  logic [3:0] i_op,
    output ctrl_t      o_ctrl
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        o_ctrl = '0;
        case (i_op)
            OP_NOP: o_ctrl.legal = 1'b1;
            OP_MOV: begin
                o_ctrl.legal  = 1'b1;
                o_ctrl.rd_sel = RD_RA;
                o_ctrl.wen    = 1'b1;
                o_ctrl.src_rb = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_ctrl.legal  = 1'b1;
                o_ctrl.rd_sel = RD_RA;
                o_ctrl.wen    = 1'b1;
                o_ctrl.src_ra = 1'b1;
                o_ctrl.src_rb = 1'b1;
            end
            OP_PUSH: begin
                o_ctrl.legal  = 1'b1;
                o_ctrl.mem_wr = 1'b1;
                o_ctrl.sp_en  = 1'b1;
                o_ctrl.src_rb = 1'b1;
                o_ctrl.src_sp = 1'b1;
            end
            OP_POP: begin
                o_ctrl.legal  = 1'b1;
                o_ctrl.rd_sel = RD_RB;
                o_ctrl.wen    = 1'b1;
                o_ctrl.mem_rd = 1'b1;
                o_ctrl.sp_en  = 1'b1;
                o_ctrl.sp_op  = 1'b1;
                o_ctrl.src_sp = 1'b1;
            end
            OP_LDM: begin
                o_ctrl.legal    = 1'b1;
                o_ctrl.two_byte = 1'b1;
                o_ctrl.rd_sel   = RD_RB;
                o_ctrl.wen      = 1'b1;
                o_ctrl.use_imm  = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: LDM two-byte FSM, load-use hazard, ID/EX register.
// Optional macro DECODE_TRAP_EN makes `illegal` sticky and blocks fetch until flush/reset.
module decode_stage
    import isa_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    output logic              if_ready,
    input  logic              ex_stall,
    input  logic              flush,
    output logic [1:0]        rf_ra,
    output logic [1:0]        rf_rb,
    output logic              id_valid,
    output logic [3:0]        id_alu_op,
    output logic [1:0]        id_rd,
    output logic              id_wen,
    output logic              id_sp_en,
    output logic              id_sp_op,
    output logic              id_mem_rd,
    output logic              id_mem_wr,
    output logic [DATA_W-1:0] id_imm,
    output logic              id_use_imm,
    output logic              illegal
);

    state_t     r_state;
    logic [1:0] r_lat_ra;
    logic [1:0] r_lat_rb;
    idex_t      r_idex;

    logic [3:0] w_op;
    ctrl_t      w_ctrl;
    idex_t      w_issue;
    logic       w_hazard;
    logic       w_trap_block;
    logic       w_accept;
    logic       w_illegal_seen;

    // While waiting for the LDM immediate, the ROM keeps describing the LDM.
    assign w_op = (r_state == S_IMM) ? OP_LDM : if_instr[7:4];

    decode_rom u_rom (
        .i_op   (w_op),
        .o_ctrl (w_ctrl)
    );

    assign rf_ra = (r_state == S_IMM) ? r_lat_ra : if_instr[3:2];
    assign rf_rb = (r_state == S_IMM) ? r_lat_rb : if_instr[1:0];

    assign w_hazard = (r_state == S_OP) && id_valid && id_mem_rd &&
                      ((w_ctrl.src_ra && (id_rd == if_instr[3:2])) ||
                       (w_ctrl.src_rb && (id_rd == if_instr[1:0])) ||
                       (w_ctrl.src_sp && (id_rd == SP_IDX)));

`ifdef DECODE_TRAP_EN
    assign w_trap_block = illegal;
`else
    assign w_trap_block = 1'b0;
`endif

    assign if_ready       = !ex_stall && !flush && !w_hazard && !w_trap_block;
    assign w_accept       = if_valid && if_ready;
    assign w_illegal_seen = w_accept && (r_state == S_OP) && !w_ctrl.legal;

    always_comb begin
        w_issue         = '0;
        w_issue.valid   = 1'b1;
        w_issue.alu_op  = w_op;
        w_issue.wen     = w_ctrl.wen;
        w_issue.sp_en   = w_ctrl.sp_en;
        w_issue.sp_op   = w_ctrl.sp_op;
        w_issue.mem_rd  = w_ctrl.mem_rd;
        w_issue.mem_wr  = w_ctrl.mem_wr;
        w_issue.use_imm = w_ctrl.use_imm;
        w_issue.imm     = w_ctrl.use_imm ? if_instr : '0;
        case (w_ctrl.rd_sel)
            RD_RA:   w_issue.rd = rf_ra;
            RD_RB:   w_issue.rd = rf_rb;
            default: w_issue.rd = 2'd0;
        endcase
        if (!w_ctrl.legal && ILLEGAL_AS_NOP)
            w_issue = '0;
    end

    // NOTE: state uses non-blocking assignments and the async active-low reset
    // so every register updates from pre-edge values in one consistent step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_OP;
            r_lat_ra <= 2'd0;
            r_lat_rb <= 2'd0;
            r_idex   <= '0;
            illegal  <= 1'b0;
        end else if (flush) begin
            r_state <= S_OP;
            r_idex  <= '0;
            illegal <= 1'b0;
        end else if (!ex_stall) begin
            if (!w_accept) begin
                r_idex <= '0;
            end else if (r_state == S_IMM) begin
                r_idex  <= w_issue;
                r_state <= S_OP;
            end else if (w_ctrl.two_byte) begin
                r_idex   <= '0;
                r_state  <= S_IMM;
                r_lat_ra <= if_instr[3:2];
                r_lat_rb <= if_instr[1:0];
            end else begin
                r_idex <= w_issue;
            end
`ifdef DECODE_TRAP_EN
            if (w_illegal_seen)
                illegal <= 1'b1;
`else
            illegal <= w_illegal_seen;
`endif
        end
    end

    assign id_valid   = r_idex.valid;
    assign id_alu_op  = r_idex.alu_op;
    assign id_rd      = r_idex.rd;
    assign id_wen     = r_idex.wen;
    assign id_sp_en   = r_idex.sp_en;
    assign id_sp_op   = r_idex.sp_op;
    assign id_mem_rd  = r_idex.mem_rd;
    assign id_mem_wr  = r_idex.mem_wr;
    assign id_imm     = r_idex.imm;
    assign id_use_imm = r_idex.use_imm;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan sequences with literal
// expectations, then randomized traffic compared every cycle to a behavioural model.
module tb_decode_stage;

    localparam bit ILLEGAL_AS_NOP = 1'b1;
`ifdef DECODE_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       if_valid = 1'b0;
    logic [7:0] if_instr = 8'h00;
    logic       ex_stall = 1'b0;
    logic       flush = 1'b0;
    logic       if_ready;
    logic [1:0] rf_ra, rf_rb;
    logic       id_valid;
    logic [3:0] id_alu_op;
    logic [1:0] id_rd;
    logic       id_wen, id_sp_en, id_sp_op, id_mem_rd, id_mem_wr;
    logic [7:0] id_imm;
    logic       id_use_imm;
    logic       illegal;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(8), .ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .if_ready(if_ready), .ex_stall(ex_stall), .flush(flush),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rd(id_rd), .id_wen(id_wen), .id_sp_en(id_sp_en), .id_sp_op(id_sp_op),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .illegal(illegal)
    );

    typedef struct packed {
        logic       valid;
        logic [3:0] op;
        logic [1:0] rd;
        logic       wen, sp_en, sp_op, mem_rd, mem_wr;
        logic [7:0] imm;
        logic       use_imm;
    } word_t;

    word_t      m_word;
    logic       m_ill;
    logic       m_pend;
    logic [7:0] m_first;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Decoded meaning of an instruction straight from the opcode table.
    function automatic word_t decode(input logic [7:0] b, input logic [7:0] imm);
        word_t w;
        w       = '0;
        w.valid = 1'b1;
        w.op    = b[7:4];
        case (b[7:4])
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin w.rd = b[3:2]; w.wen = 1'b1; end
            4'h7: begin w.mem_wr = 1'b1; w.sp_en = 1'b1; end
            4'h8: begin w.rd = b[1:0]; w.wen = 1'b1; w.mem_rd = 1'b1; w.sp_en = 1'b1; w.sp_op = 1'b1; end
            4'hC: begin w.rd = b[1:0]; w.wen = 1'b1; w.use_imm = 1'b1; w.imm = imm; end
            default: if (ILLEGAL_AS_NOP) w = '0;
        endcase
        return w;
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hC};
    endfunction

    function automatic bit reads_reg(input logic [7:0] b, input logic [1:0] r);
        case (b[7:4])
            4'h1:                   return r == b[1:0];
            4'h2, 4'h3, 4'h4, 4'h5: return (r == b[3:2]) || (r == b[1:0]);
            4'h7:                   return (r == b[1:0]) || (r == 2'd3);
            4'h8:                   return r == 2'd3;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic bit exp_ready();
        bit hazard;
        hazard = !m_pend && m_word.valid && m_word.mem_rd && reads_reg(if_instr, m_word.rd);
        return !ex_stall && !flush && !hazard && !(TRAP && m_ill);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_word = '0; m_ill = 1'b0; m_pend = 1'b0; m_first = 8'h00;
        end else if (flush) begin
            m_word = '0; m_ill = 1'b0; m_pend = 1'b0;
        end else if (!ex_stall) begin
            bit acc;
            bit ill_now;
            acc     = if_valid && exp_ready();
            ill_now = acc && !m_pend && !is_legal(if_instr[7:4]);
            if (!acc) begin
                m_word = '0;
            end else if (m_pend) begin
                m_word = decode(m_first, if_instr);
                m_pend = 1'b0;
            end else if (if_instr[7:4] == 4'hC) begin
                m_word  = '0;
                m_pend  = 1'b1;
                m_first = if_instr;
            end else begin
                m_word = decode(if_instr, 8'h00);
            end
            m_ill = TRAP ? (m_ill || ill_now) : ill_now;
        end
    end

    task automatic check_model();
        check("if_ready", if_ready, exp_ready());
        check("rf_ra", rf_ra, m_pend ? m_first[3:2] : if_instr[3:2]);
        check("rf_rb", rf_rb, m_pend ? m_first[1:0] : if_instr[1:0]);
        check("id_valid", id_valid, m_word.valid);
        check("id_alu_op", id_alu_op, m_word.op);
        check("id_rd", id_rd, m_word.rd);
        check("id_wen", id_wen, m_word.wen);
        check("id_sp_en", id_sp_en, m_word.sp_en);
        check("id_sp_op", id_sp_op, m_word.sp_op);
        check("id_mem_rd", id_mem_rd, m_word.mem_rd);
        check("id_mem_wr", id_mem_wr, m_word.mem_wr);
        check("id_imm", id_imm, m_word.imm);
        check("id_use_imm", id_use_imm, m_word.use_imm);
        check("illegal", illegal, m_ill);
    endtask

    task automatic drive(input bit v, input logic [7:0] b, input bit st, input bit fl);
        @(negedge clk);
        if_valid = v; if_instr = b; ex_stall = st; flush = fl;
        #1;
        check_model();
    endtask

    initial begin
        logic [3:0] ops [10];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hC, 4'h8};

        repeat (2) @(negedge clk);
        #1;
        check_model();
        check("reset id_valid", id_valid, 0);
        check("reset illegal", illegal, 0);
        check("reset if_ready", if_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // ADD R1,R2
        drive(1, 8'h26, 0, 0);
        check("add rf_ra", rf_ra, 1);
        check("add rf_rb", rf_rb, 2);
        drive(0, 8'h00, 0, 0);
        check("add id_valid", id_valid, 1);
        check("add id_alu_op", id_alu_op, 2);
        check("add id_rd", id_rd, 1);
        check("add id_wen", id_wen, 1);

        // LDM R2, #0x5A
        drive(1, 8'hC2, 0, 0);
        drive(1, 8'h5A, 0, 0);
        check("ldm bubble", id_valid, 0);
        check("ldm rf_ra", rf_ra, 0);
        check("ldm rf_rb", rf_rb, 2);
        drive(0, 8'h00, 0, 0);
        check("ldm id_valid", id_valid, 1);
        check("ldm id_rd", id_rd, 2);
        check("ldm id_imm", id_imm, 8'h5A);
        check("ldm id_use_imm", id_use_imm, 1);
        check("ldm id_wen", id_wen, 1);

        // POP R1 then ADD R1,R0: load-use bubble
        drive(1, 8'h81, 0, 0);
        drive(1, 8'h24, 0, 0);
        check("pop id_sp_en", id_sp_en, 1);
        check("pop id_sp_op", id_sp_op, 1);
        check("pop id_rd", id_rd, 1);
        check("hazard if_ready", if_ready, 0);
        drive(1, 8'h24, 0, 0);
        check("hazard bubble", id_valid, 0);
        check("hazard cleared", if_ready, 1);
        drive(0, 8'h00, 0, 0);
        check("post-hazard add", id_alu_op, 2);
        check("post-hazard valid", id_valid, 1);

        // PUSH R2 held by ex_stall
        drive(1, 8'h72, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h10, 1, 0);
            check("stall if_ready", if_ready, 0);
            check("stall id_mem_wr", id_mem_wr, 1);
            check("stall id_sp_op", id_sp_op, 0);
            check("stall id_valid", id_valid, 1);
        end
        drive(0, 8'h00, 0, 0);
        check("stall release push", id_mem_wr, 1);

        // Flush between LDM and its immediate
        drive(1, 8'hC1, 0, 0);
        drive(1, 8'h33, 0, 1);
        check("flush if_ready", if_ready, 0);
        drive(1, 8'h10, 0, 0);
        check("flush id_valid", id_valid, 0);
        check("flush back to S_OP rf_rb", rf_rb, 0);
        drive(0, 8'h00, 0, 0);
        check("mov id_valid", id_valid, 1);
        check("mov id_alu_op", id_alu_op, 1);
        check("mov id_use_imm", id_use_imm, 0);

        // Illegal opcode
        drive(1, 8'hF0, 0, 0);
        drive(0, 8'h00, 0, 0);
        check("illegal pulse", illegal, 1);
        check("illegal id_valid", id_valid, 0);
        check("illegal id_wen", id_wen, 0);
`ifdef DECODE_TRAP_EN
        drive(1, 8'h10, 0, 0);
        check("trap if_ready", if_ready, 0);
        check("trap sticky", illegal, 1);
        drive(1, 8'h10, 0, 1);
        drive(0, 8'h00, 0, 0);
        check("trap cleared", illegal, 0);
        check("trap if_ready back", if_ready, 1);
`else
        drive(0, 8'h00, 0, 0);
        check("illegal one cycle", illegal, 0);
        check("illegal if_ready", if_ready, 1);
`endif

        // Reset while an LDM waits for its immediate
        drive(1, 8'hC3, 0, 0);
        @(negedge clk);
        if_valid = 1'b0; if_instr = 8'h10;
        #2 rst = 1'b0;
        #1;
        check_model();
        check("rst mid-ldm rf_rb", rf_rb, 0);
        check("rst mid-ldm id_valid", id_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 8'h14, 0, 0);
        drive(0, 8'h00, 0, 0);
        check("after rst mov op", id_alu_op, 1);
        check("after rst mov rd", id_rd, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [7:0] b;
            b[3:0] = 4'($urandom);
            b[7:4] = ($urandom_range(0, 15) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
            drive($urandom_range(0, 3) != 0, b, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 24) == 0);
        end
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
